// File: rtl/uart_io_pkg.sv
// Shared types for the UART IN/OUT sequencer: FSM states, completion codes, status bit positions.
// Pure declarations; no timing or flow control of its own.
package uart_io_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ST_AR,
    ST_R,
    GAP,
    DAT_AR,
    DAT_R,
    TX_AW,
    TX_B,
    DONE
  } io_state_t;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_BUS     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int STAT_RX_VALID = 0;
  localparam int STAT_TX_FULL  = 3;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/axil_single_master.sv
// One-shot AXI4-Lite master: a start pulse launches a single read (AR/R) or write (AW/W/B); VALIDs
// rise one cycle after start and hold until their handshake, so slave READY stalls are absorbed.
module axil_single_master (
  input  logic        CLK,
  input  logic        RST,
  input  logic        rd_start,
  input  logic        wr_start,
  input  logic [3:0]  addr,
  input  logic [7:0]  wbyte,
  output logic        ar_hs,
  output logic        rd_done,
  output logic [1:0]  rd_resp,
  output logic [7:0]  rd_byte,
  output logic        wr_sent,
  output logic        wr_done,
  output logic [1:0]  wr_resp,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  logic wr_active;
  logic unused_rdata_hi;

  assign ar_hs   = ARVALID & ARREADY;
  assign rd_done = RVALID & RREADY;
  assign rd_resp = RRESP;
  assign rd_byte = RDATA[7:0];
  assign wr_done = BVALID & BREADY;
  assign wr_resp = BRESP;
  assign WSTRB   = 4'b0001;
  assign unused_rdata_hi = ^RDATA[31:8];

  // AW and W retire independently; the write is fully sent once neither is still pending after this edge.
  assign wr_sent = wr_active & ~(AWVALID & ~AWREADY) & ~(WVALID & ~WREADY);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ARADDR    <= '0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      AWADDR    <= '0;
      AWVALID   <= 1'b0;
      WDATA     <= '0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      wr_active <= 1'b0;
    end else begin
      if (rd_start) begin
        ARADDR  <= addr;
        ARVALID <= 1'b1;
      end else if (ar_hs) begin
        ARVALID <= 1'b0;
        RREADY  <= 1'b1;
      end
      if (rd_done) RREADY <= 1'b0;

      if (wr_start) begin
        AWADDR    <= addr;
        WDATA     <= {24'b0, wbyte};
        AWVALID   <= 1'b1;
        WVALID    <= 1'b1;
        wr_active <= 1'b1;
      end else begin
        if (AWVALID && AWREADY) AWVALID <= 1'b0;
        if (WVALID && WREADY)   WVALID  <= 1'b0;
        if (wr_sent) begin
          wr_active <= 1'b0;
          BREADY    <= 1'b1;
        end
      end
      if (wr_done) BREADY <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_io_ctrl.sv
// Executes core IN/OUT byte requests against an AXI4-Lite UART: polls status, moves the byte, pulses a response.
// One request in flight; REQ_READY only in IDLE, so the core holds its request until accepted.
module uart_io_ctrl
  import uart_io_pkg::*;
#(
  parameter logic [3:0]  STAT_ADDR = 4'h8,
  parameter logic [3:0]  RX_ADDR   = 4'h0,
  parameter logic [3:0]  TX_ADDR   = 4'h4,
  parameter int unsigned POLL_GAP  = 4,
  parameter int unsigned MAX_POLLS = 0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [7:0]  REQ_WDATA,
  output logic        RSP_VALID,
  output logic [7:0]  RSP_RDATA,
  output logic [1:0]  RSP_ERR,
  output logic        BUSY,
  output logic [3:0]  ARADDR,
  output logic        ARVALID,
  input  logic        ARREADY,
  input  logic [31:0] RDATA,
  input  logic [1:0]  RRESP,
  input  logic        RVALID,
  output logic        RREADY,
  output logic [3:0]  AWADDR,
  output logic        AWVALID,
  input  logic        AWREADY,
  output logic [31:0] WDATA,
  output logic [3:0]  WSTRB,
  output logic        WVALID,
  input  logic        WREADY,
  input  logic [1:0]  BRESP,
  input  logic        BVALID,
  output logic        BREADY
);

  localparam logic [15:0] MAX_P    = MAX_POLLS[15:0];
  localparam logic [15:0] GAP_LAST = (POLL_GAP == 0) ? 16'd0 : 16'(POLL_GAP - 1);

  io_state_t   state;
  logic        is_wr;
  logic [7:0]  tx_byte;
  logic [15:0] poll_cnt;
  logic [15:0] gap_cnt;
  logic        rd_start;
  logic        wr_start;
  logic [3:0]  ax_addr;

  logic        ar_hs;
  logic        rd_done;
  logic [1:0]  rd_resp;
  logic [7:0]  rd_byte;
  logic        wr_sent;
  logic        wr_done;
  logic [1:0]  wr_resp;
  logic        poll_ok;
  logic [15:0] poll_nxt;

  assign poll_ok  = is_wr ? ~rd_byte[STAT_TX_FULL] : rd_byte[STAT_RX_VALID];
  assign poll_nxt = sat_inc16(poll_cnt);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      REQ_READY <= 1'b1;
      BUSY      <= 1'b0;
      RSP_VALID <= 1'b0;
      RSP_RDATA <= '0;
      RSP_ERR   <= ERR_OK;
      is_wr     <= 1'b0;
      tx_byte   <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      rd_start  <= 1'b0;
      wr_start  <= 1'b0;
      ax_addr   <= '0;
    end else begin
      rd_start  <= 1'b0;
      wr_start  <= 1'b0;
      RSP_VALID <= 1'b0;
      case (state)
        IDLE: if (REQ_VALID) begin
          is_wr     <= REQ_WRITE;
          tx_byte   <= REQ_WDATA;
          poll_cnt  <= '0;
          REQ_READY <= 1'b0;
          BUSY      <= 1'b1;
          rd_start  <= 1'b1;
          ax_addr   <= STAT_ADDR;
          state     <= ST_AR;
        end
        ST_AR: if (ar_hs) state <= ST_R;
        ST_R: if (rd_done) begin
          if (rd_resp != 2'b00) begin
            RSP_VALID <= 1'b1;
            RSP_ERR   <= ERR_BUS;
            state     <= DONE;
          end else if (poll_ok) begin
            if (is_wr) begin
              wr_start <= 1'b1;
              ax_addr  <= TX_ADDR;
              state    <= TX_AW;
            end else begin
              rd_start <= 1'b1;
              ax_addr  <= RX_ADDR;
              state    <= DAT_AR;
            end
          end else begin
            poll_cnt <= poll_nxt;
            if (MAX_POLLS != 0 && poll_nxt == MAX_P) begin
              RSP_VALID <= 1'b1;
              RSP_ERR   <= ERR_TIMEOUT;
              state     <= DONE;
            end else if (POLL_GAP == 0) begin
              rd_start <= 1'b1;
              ax_addr  <= STAT_ADDR;
              state    <= ST_AR;
            end else begin
              gap_cnt <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            rd_start <= 1'b1;
            ax_addr  <= STAT_ADDR;
            state    <= ST_AR;
          end else begin
            gap_cnt <= gap_cnt + 16'd1;
          end
        end
        DAT_AR: if (ar_hs) state <= DAT_R;
        DAT_R: if (rd_done) begin
          RSP_RDATA <= rd_byte;
          RSP_VALID <= 1'b1;
          RSP_ERR   <= (rd_resp != 2'b00) ? ERR_BUS : ERR_OK;
          state     <= DONE;
        end
        TX_AW: if (wr_sent) state <= TX_B;
        TX_B: if (wr_done) begin
          RSP_VALID <= 1'b1;
          RSP_ERR   <= (wr_resp != 2'b00) ? ERR_BUS : ERR_OK;
          state     <= DONE;
        end
        DONE: begin
          REQ_READY <= 1'b1;
          BUSY      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  axil_single_master u_axil (
    .CLK      (CLK),
    .RST      (RST),
    .rd_start (rd_start),
    .wr_start (wr_start),
    .addr     (ax_addr),
    .wbyte    (tx_byte),
    .ar_hs    (ar_hs),
    .rd_done  (rd_done),
    .rd_resp  (rd_resp),
    .rd_byte  (rd_byte),
    .wr_sent  (wr_sent),
    .wr_done  (wr_done),
    .wr_resp  (wr_resp),
    .ARADDR   (ARADDR),
    .ARVALID  (ARVALID),
    .ARREADY  (ARREADY),
    .RDATA    (RDATA),
    .RRESP    (RRESP),
    .RVALID   (RVALID),
    .RREADY   (RREADY),
    .AWADDR   (AWADDR),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY)
  );

endmodule
